ub_result_packer: RTL
=====================

// Module: ub_result_packer
// PURPOSE
//  Sits directly downstream of activation_pipeline and consumes its int8 results (valid_out/ub_data_out).
//  Packs the byte stream into 32-bit words and writes them to the unified buffer at sequential addresses.
//  Uses a ready/valid write port. A small word FIFO absorbs UB back-pressure, because the activation
//  pipeline cannot stall.
// PARAMETERS
//  BYTES_PER_WORD  4   bytes packed per UB word (power of 2)
//  ADDR_W          16  UB word-address width
//  LEN_W           16  byte-count width of a transfer
//  FIFO_DEPTH      4   packed-word FIFO entries (power of 2, >=2)
// PORTS
//  clk            in   1          clock
//  rst            in   1          synchronous reset, active-high
//  start          in   1          begin transfer; sampled only in IDLE
//  base_addr      in   ADDR_W     UB word address of first word
//  num_bytes      in   LEN_W      bytes to collect this transfer
//  valid_in       in   1          byte strobe from activation_pipeline.valid_out
//  data_in        in   8          byte from activation_pipeline.ub_data_out
//  ub_wr_valid    out  1          write request
//  ub_wr_ready    in   1          UB accepts write this cycle
//  ub_wr_addr     out  ADDR_W     write word address
//  ub_wr_data     out  8*BPW      packed word, byte k in [8k+7:8k]
//  ub_wr_strb     out  BPW        byte enables (partial final word)
//  busy           out  1          high from the cycle after start until done
//  done           out  1          one-cycle pulse when the transfer is complete
//  overflow_err   out  1          sticky: a word was dropped because the FIFO was full
//  drop_err       out  1          sticky: valid_in arrived in IDLE/DRAIN or after num_bytes
// BEHAVIOUR
//  Reset: all outputs are 0. The FSM goes to IDLE. The FIFO, counters and both sticky errors are cleared.
//   This is identical when reset is asserted mid-transfer: the partial word and FIFO contents are discarded.
//  FSM states: IDLE, PACK, DRAIN, DONE.
//   - IDLE: on start, latch base_addr and num_bytes and clear lane/byte counters.
//     - num_bytes == 0: go to DONE.
//     - otherwise: go to PACK.
//     - Sticky errors clear on start.
//   - PACK: each valid_in byte is written into lane byte_cnt % BPW of the assembly register.
//     - The word is pushed to the FIFO on the edge that samples lane BPW-1, or the final byte (byte_cnt == num_bytes-1).
//     - Each push carries {data, strb, addr = base + word_idx}. Unfilled lanes have strb = 0 and data = 0.
//     - word_idx increments on every push attempt, including dropped ones, so later words keep correct addresses.
//     - After the final byte is sampled, go to DRAIN.
//   - DRAIN: wait until the FIFO is empty and no write is outstanding, then go to DONE.
//   - DONE: assert done for exactly 1 cycle, then go to IDLE. busy is 0 in IDLE and DONE.
//  Start handling:
//   - start outside IDLE is ignored.
//   - start and valid_in in the same IDLE cycle: the byte is dropped (drop_err set).
//     The upstream must start the pipeline at least 1 cycle after start.
//  FIFO is first-word-fall-through.
//   - ub_wr_valid = !fifo_empty.
//   - addr/data/strb come from the FIFO head and are held stable while valid && !ready.
//   - Pop on ub_wr_valid && ub_wr_ready.
//   - Latency: from the edge sampling a word-completing byte to ub_wr_valid high is 1 cycle (empty FIFO, ready high).
//   - Push on full: allowed if a pop occurs the same cycle; otherwise the word is dropped and overflow_err is set.
//   - Simultaneous push/pop on empty: the push lands, and the popped entry is the previous head only.
//  Address arithmetic: base + word_idx is modulo 2^ADDR_W (wraps silently).
//  Throughput: 1 byte/cycle in, so there is a sustained need of 1 write per BPW cycles; any rate is safe with ready always high.
// STRUCTURE
//  Shared package tpu_out_pkg:
//   - typedef enum {IDLE, PACK, DRAIN, DONE} packer_state_t
//   - localparams for BPW/ADDR_W defaults
//   - packed struct ub_wr_t {addr, data, strb}
//  Sub-module: sync_fifo_fwft (parametric width/depth; full/empty; push/pop).
//   It stores ub_wr_t and is reusable by other UB writers.
//  Top: FSM, lane/byte/word counters, assembly register, error flags.
// TESTING
//  1. start, base=0x0100, n=8, bytes 01..08 back-to-back, ready=1
//     -> writes 0x04030201@0x0100 and 0x08070605@0x0101, strb=4'hF, then done pulse.
//  2. n=6, bytes AA..AF
//     -> second write data 0x0000AFAE strb=4'b0011 @base+1.
//  3. n=0
//     -> no write, done pulses 2 cycles after start, busy stays 0.
//  4. ready=0 for 40 cycles, n=32 at 1 byte/cycle, FIFO_DEPTH=4
//     -> overflow_err=1, exactly 4 words written once ready rises, addrs of dropped words skipped.
//  5. ready toggled randomly, n=64
//     -> all 16 words in order, addr/data stable during stalls, done after last handshake.
//  6. base=0xFFFF, n=8
//     -> writes @0xFFFF then @0x0000.
//  7. rst asserted mid-PACK with 2 bytes in flight
//     -> next cycle: all outputs 0, state IDLE.
//  8. valid_in pulse in IDLE
//     -> drop_err=1, no write.

Source files
------------

// File: rtl/tpu_out_pkg.sv
// ============================================================================
// Module : tpu_out_pkg
// Brief  : Shared types for unified-buffer writers (state enum, write entry).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tpu_out_pkg;

  localparam int UB_BPW    = 4;
  localparam int UB_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } packer_state_t;

  typedef struct packed {
    logic [UB_ADDR_W-1:0] addr;
    logic [8*UB_BPW-1:0]  data;
    logic [UB_BPW-1:0]    strb;
  } ub_wr_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
// ============================================================================
// Module : sync_fifo_fwft
// Brief  : First-word-fall-through synchronous FIFO; head is visible on data_o.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_fwft
  import tpu_out_pkg::*;
#(
  parameter type T     = ub_wr_t,
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  T           mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        do_push;
  logic        do_pop;

  // Extra pointer MSB distinguishes full from empty when indices match.
  always_comb begin
    empty_o = (wr_ptr_q == rd_ptr_q);
    full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    data_o  = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/ub_result_packer.sv
// ============================================================================
// Module : ub_result_packer
// Brief  : Packs an int8 result stream into UB words and writes them in order.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ub_result_packer
  import tpu_out_pkg::*;
#(
  parameter int BYTES_PER_WORD = UB_BPW,
  parameter int ADDR_W         = UB_ADDR_W,
  parameter int LEN_W          = 16,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic [LEN_W-1:0]            num_bytes,
  input  logic                        valid_in,
  input  logic [7:0]                  data_in,
  output logic                        ub_wr_valid,
  input  logic                        ub_wr_ready,
  output logic [ADDR_W-1:0]           ub_wr_addr,
  output logic [8*BYTES_PER_WORD-1:0] ub_wr_data,
  output logic [BYTES_PER_WORD-1:0]   ub_wr_strb,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow_err,
  output logic                        drop_err
);

  localparam int DATA_W = 8 * BYTES_PER_WORD;
  localparam int LANE_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0]         addr;
    logic [DATA_W-1:0]         data;
    logic [BYTES_PER_WORD-1:0] strb;
  } wr_entry_t;

  packer_state_t             state_q;
  logic [ADDR_W-1:0]         base_q;
  logic [ADDR_W-1:0]         word_idx_q;
  logic [LEN_W-1:0]          len_q;
  logic [LEN_W-1:0]          byte_cnt_q;
  logic [DATA_W-1:0]         asm_data_q;
  logic [DATA_W-1:0]         asm_data_d;
  logic [BYTES_PER_WORD-1:0] asm_strb_q;
  logic [BYTES_PER_WORD-1:0] asm_strb_d;
  logic                      busy_q;
  logic                      done_q;
  logic                      overflow_q;
  logic                      drop_q;

  logic [LANE_W-1:0] lane;
  logic              last_lane;
  logic              final_byte;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  wr_entry_t         push_entry;
  wr_entry_t         head;

  always_comb begin
    lane       = byte_cnt_q[LANE_W-1:0];
    last_lane  = (lane == LANE_W'(BYTES_PER_WORD - 1));
    final_byte = (byte_cnt_q == len_q - LEN_W'(1));
    asm_data_d = asm_data_q;
    asm_strb_d = asm_strb_q;
    asm_data_d[{lane, 3'b000} +: 8] = data_in;
    asm_strb_d[lane]                = 1'b1;
    push       = (state_q == PACK) && valid_in && (last_lane || final_byte);
    push_entry.addr = base_q + word_idx_q;
    push_entry.data = asm_data_d;
    push_entry.strb = asm_strb_d;
  end

  sync_fifo_fwft #(
    .T     (wr_entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Head fields are masked so the write port reads all-zero whenever idle.
  assign ub_wr_valid  = !fifo_empty;
  assign pop          = ub_wr_valid && ub_wr_ready;
  assign ub_wr_addr   = ub_wr_valid ? head.addr : '0;
  assign ub_wr_data   = ub_wr_valid ? head.data : '0;
  assign ub_wr_strb   = ub_wr_valid ? head.strb : '0;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overflow_err = overflow_q;
  assign drop_err     = drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      word_idx_q <= '0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      asm_data_q <= '0;
      asm_strb_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            base_q     <= base_addr;
            len_q      <= num_bytes;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            asm_data_q <= '0;
            asm_strb_q <= '0;
            overflow_q <= 1'b0;
            // A byte arriving alongside start cannot be captured.
            drop_q     <= valid_in;
            if (num_bytes == '0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= PACK;
              busy_q  <= 1'b1;
            end
          end else if (valid_in) begin
            drop_q <= 1'b1;
          end
        end
        PACK: begin
          if (valid_in) begin
            byte_cnt_q <= byte_cnt_q + 1'b1;
            if (last_lane || final_byte) begin
              word_idx_q <= word_idx_q + 1'b1;
              asm_data_q <= '0;
              asm_strb_q <= '0;
            end else begin
              asm_data_q <= asm_data_d;
              asm_strb_q <= asm_strb_d;
            end
            if (final_byte) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (valid_in) drop_q <= 1'b1;
          if (fifo_empty) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          if (valid_in) drop_q <= 1'b1;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

endmodule

`default_nettype wire
